// File: rtl/gate_bist_if.sv
// rtl/gate_bist_if.sv - gate_bist handshake and result bus
// Purpose: groups the run request, gate-under-test connection and result
//          signals of gate_bist into one bundle.
// Ports (signals):
//   start      run request (master -> slave)
//   truth[3:0] expected gate output per vector (master -> slave)
//   y          gate-under-test output (master -> slave)
//   ta, tb     gate inputs driven by the sequencer (slave -> master)
//   busy, done run in progress / end-of-run pulse (slave -> master)
//   pass, err_cnt, fail_vec, fail_valid  results of the last run (slave -> master)
interface gate_bist_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic [3:0]       truth;
   logic             y;
   logic             ta;
   logic             tb;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [1:0]       fail_vec;
   logic             fail_valid;

   modport master (
      output start, truth, y,
      input  ta, tb, busy, done, pass, err_cnt, fail_vec, fail_valid
   );

   modport slave (
      input  start, truth, y,
      output ta, tb, busy, done, pass, err_cnt, fail_vec, fail_valid
   );
endinterface

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - built-in self-test sequencer for a 2-input gate
// Purpose: sweeps the four input vectors onto a gate under test, holds each
//          for SETTLE cycles, samples y on the last cycle and compares it with
//          truth[vec]; repeats PASSES times, then reports pass, a saturating
//          error count and the first failing vector.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    gate_bist_if.slave: start/truth/y in; ta/tb/busy/done/pass/
//          err_cnt/fail_vec/fail_valid out
module gate_bist #(
   parameter int SETTLE = 2,
   parameter int PASSES = 1,
   parameter int ERR_W  = 8
) (
   input logic       clk,
   input logic       rst_n,
   gate_bist_if.slave bus
);
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int SW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE - 1);
   localparam logic [SW-1:0] SWEEP_LAST = SW'(PASSES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [SW-1:0]    sweep_q, sweep_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [1:0]       fail_vec_q, fail_vec_d;
   logic             fail_valid_q, fail_valid_d;
   logic             pass_q, pass_d;

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      sweep_d      = sweep_q;
      cnt_d        = cnt_q;
      err_cnt_d    = err_cnt_q;
      fail_vec_d   = fail_vec_q;
      fail_valid_d = fail_valid_q;
      pass_d       = pass_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d      = S_RUN;
               vec_d        = 2'd0;
               sweep_d      = '0;
               cnt_d        = '0;
               err_cnt_d    = '0;
               fail_vec_d   = 2'd0;
               fail_valid_d = 1'b0;
               pass_d       = 1'b0;
            end
         end
         S_RUN: begin
            if (cnt_q == CNT_LAST) begin
               // Last settle cycle of this vector: sample and advance.
               cnt_d = '0;
               if (bus.y != bus.truth[vec_q]) begin
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                  if (!fail_valid_q) begin
                     fail_vec_d   = vec_q;
                     fail_valid_d = 1'b1;
                  end
               end
               if (vec_q == 2'd3) begin
                  if (sweep_q == SWEEP_LAST) begin
                     state_d = S_DONE;
                     // Uses the post-sample values so the final vector counts.
                     pass_d  = (err_cnt_d == '0) && !fail_valid_d;
                  end else begin
                     vec_d   = 2'd0;
                     sweep_d = sweep_q + 1'b1;
                  end
               end else begin
                  vec_d = vec_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         vec_q        <= 2'd0;
         sweep_q      <= '0;
         cnt_q        <= '0;
         err_cnt_q    <= '0;
         fail_vec_q   <= 2'd0;
         fail_valid_q <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         sweep_q      <= sweep_d;
         cnt_q        <= cnt_d;
         err_cnt_q    <= err_cnt_d;
         fail_vec_q   <= fail_vec_d;
         fail_valid_q <= fail_valid_d;
         pass_q       <= pass_d;
      end
   end

   // Gate inputs are forced to 00 outside RUN so the gate sees a quiet pattern.
   assign bus.ta         = (state_q == S_RUN) & vec_q[0];
   assign bus.tb         = (state_q == S_RUN) & vec_q[1];
   assign bus.busy       = (state_q == S_RUN);
   assign bus.done       = (state_q == S_DONE);
   assign bus.pass       = pass_q;
   assign bus.err_cnt    = err_cnt_q;
   assign bus.fail_vec   = fail_vec_q;
   assign bus.fail_valid = fail_valid_q;
endmodule

// File: doc/gate_bist.md
# gate_bist

Built-in self-test sequencer for a 2-input combinational gate. It drives all four input vectors onto the gate under test, waits a programmable settle time, and samples the gate output. Each sample is compared against an expected 4-bit truth table, and the block reports pass/fail, an error count and the first failing vector. It is the hardware counterpart of the gate stimulus/monitor benches and sits beside any gate instance (e.g. the NAND primitive) for at-speed checking.

## Interface
Parameters:
- SETTLE, 2, cycles each vector is held before the output is sampled; legal range >= 1
- PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1
- ERR_W, 8, width of the error counter

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- truth  in  4  expected output; truth[i] is the expected y for vector i; must be stable while busy
- y  in  1  gate-under-test output
- ta  out  1  gate input a; equals vector bit 0
- tb  out  1  gate input b; equals vector bit 1
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  1 when the last run had zero mismatches
- err_cnt  out  ERR_W  mismatch count of the last run; saturating
- fail_vec  out  2  index of the first mismatching vector
- fail_valid  out  1  fail_vec holds a valid index

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - ta = tb = 0, busy = 0.
  - Results (pass, err_cnt, fail_vec, fail_valid) hold their values from the previous run.
  - start = 1 at an edge -> RUN. At the same edge: vec = 0, sweep = 0, settle counter = 0, err_cnt = 0, fail_valid = 0, fail_vec = 0, pass = 0.
- RUN:
  - {tb, ta} = vec; busy = 1.
  - The settle counter increments each cycle. On the edge where it reaches SETTLE-1, y is sampled and compared with truth[vec], and the counter resets to 0.
  - On mismatch:
    - err_cnt increments, saturating at 2^ERR_W - 1.
    - If fail_valid = 0: fail_vec = vec and fail_valid = 1. Later mismatches never overwrite fail_vec.
  - After a sample:
    - If vec = 3 and sweep = PASSES-1 -> DONE.
    - Else if vec = 3: vec = 0 and sweep increments.
    - Else vec increments.
- Vector order within a sweep: index 0,1,2,3 = (ta,tb) 00, 10, 01, 11.
- DONE:
  - Lasts one cycle: done = 1, busy = 0, ta = tb = 0.
  - pass = 1 iff err_cnt = 0 and fail_valid = 0. pass is registered on entry to DONE and is valid during the done cycle.
  - Next state is IDLE.
- start is ignored in RUN and DONE. It is never queued.
- Behaviour is undefined if truth changes while busy; verification must hold truth stable.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, ta = tb = 0, busy = 0, done = 0, pass = 0, err_cnt = 0, fail_vec = 0, fail_valid = 0, all internal counters 0. This takes effect immediately, including mid-run, and any partial run is discarded.
- Cycle numbering: the edge that samples start begins cycle 1.
- busy is high for cycles 1 .. N, where N = 4·PASSES·SETTLE.
- Vector k of the overall run is driven on cycles k·SETTLE+1 .. (k+1)·SETTLE. Its y is sampled at the edge that ends cycle (k+1)·SETTLE.
- done pulses in cycle N+1. Results are valid from cycle N+1 until the next accepted start.
- Earliest restart: start sampled at the edge ending cycle N+2, i.e. the first IDLE cycle.
- SETTLE = 1: a new vector every cycle, and y is sampled at the end of that same cycle.

## Test plan
- NAND model on y, truth = 4'b0111, SETTLE = 2, PASSES = 1, start pulse -> {ta,tb} sequence 00,00,10,10,01,01,11,11 over cycles 1-8; done in cycle 9; pass = 1, err_cnt = 0, fail_valid = 0.
- NAND model, truth = 4'b1111 -> err_cnt = 1, fail_vec = 3, fail_valid = 1, pass = 0.
- y stuck at 1, truth = 4'b0111, PASSES = 3, SETTLE = 1 -> busy for 12 cycles, done in cycle 13, err_cnt = 3, fail_vec = 3.
- ERR_W = 2, PASSES = 2, y = inverted NAND -> 8 mismatches, err_cnt saturates at 3, fail_vec = 0, pass = 0.
- start held high continuously -> restarts accepted only in IDLE (every N+2 cycles). A start pulse mid-run is ignored and the run length is unchanged.
- rst_n low in cycle 5 of a run -> all outputs 0 immediately. After release, a new start yields a clean full run with correct results.
